// File: rtl/wbuconsole_link_pkg.sv
// rtl/wbuconsole_link_pkg.sv - shared tags, grant encoding and byte helper for the console link
package wbuconsole_link_pkg;

  // Bit-7 stream markers on the link
  localparam logic TAG_BUS     = 1'b1;
  localparam logic TAG_CONSOLE = 1'b0;

  // Which transmit source was granted most recently
  typedef enum logic {
    GRANT_CON = 1'b0,
    GRANT_CMD = 1'b1
  } grant_t;

  // Build a link byte from a stream tag and a 7-bit payload
  function automatic logic [7:0] tag_byte(input logic tag, input logic [6:0] payload);
    return {tag, payload};
  endfunction

endpackage

// File: rtl/wbuconsole_link_if.sv
// rtl/wbuconsole_link_if.sv - link, transmit-source and receive-sink signals of the console link
interface wbuconsole_link_if;
  logic       i_link_stb;
  logic [7:0] i_link_data;
  logic       o_link_stb;
  logic [7:0] o_link_data;
  logic       i_link_busy;
  logic       i_cmd_stb;
  logic [6:0] i_cmd_data;
  logic       o_cmd_busy;
  logic       i_con_stb;
  logic [6:0] i_con_data;
  logic       o_con_busy;
  logic       o_rsp_stb;
  logic [6:0] o_rsp_data;
  logic       i_rsp_ready;
  logic       o_conrx_stb;
  logic [6:0] o_conrx_data;
  logic       i_conrx_ready;
  logic       i_clr_overflow;
  logic [1:0] o_overflow;

  // The link block itself
  modport slave (
    input  i_link_stb, i_link_data, i_link_busy,
    input  i_cmd_stb, i_cmd_data, i_con_stb, i_con_data,
    input  i_rsp_ready, i_conrx_ready, i_clr_overflow,
    output o_link_stb, o_link_data, o_cmd_busy, o_con_busy,
    output o_rsp_stb, o_rsp_data, o_conrx_stb, o_conrx_data, o_overflow
  );

  // Whatever drives the link block (link PHY plus local sources/sinks)
  modport master (
    output i_link_stb, i_link_data, i_link_busy,
    output i_cmd_stb, i_cmd_data, i_con_stb, i_con_data,
    output i_rsp_ready, i_conrx_ready, i_clr_overflow,
    input  o_link_stb, o_link_data, o_cmd_busy, o_con_busy,
    input  o_rsp_stb, o_rsp_data, o_conrx_stb, o_conrx_data, o_overflow
  );
endinterface

// File: rtl/wbuconsole_fifo.sv
// rtl/wbuconsole_fifo.sv - first-word-fall-through receive FIFO with push-accept indication
module wbuconsole_fifo #(
  parameter int WIDTH  = 7,
  parameter int LGFIFO = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic             push_ok
);

  localparam int DEPTH = 1 << LGFIFO;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [LGFIFO:0]  wr_ptr;
  logic [LGFIFO:0]  rd_ptr;
  logic             pop_ok;

  // One extra pointer bit tells full (MSBs differ) from empty (all equal)
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[LGFIFO] != rd_ptr[LGFIFO]) &&
                   (wr_ptr[LGFIFO-1:0] == rd_ptr[LGFIFO-1:0]);
  assign pop_ok  = pop && !empty;
  // A pop in the same cycle frees the slot the push lands in
  assign push_ok = push && (!full || pop_ok);
  // Head is forced to zero while empty so nothing stale leaks out
  assign head    = empty ? '0 : mem[rd_ptr[LGFIFO-1:0]];

  // Pointer update; wraps naturally modulo 2^(LGFIFO+1)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since empty masks the head
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[LGFIFO-1:0]] <= push_data;
  end

endmodule

// File: rtl/wbuconsole_link.sv
// rtl/wbuconsole_link.sv - link-side demux of responses/console and round-robin transmit merge
module wbuconsole_link
  import wbuconsole_link_pkg::*;
#(
  parameter int LGFIFO = 4
) (
  input logic              i_clk,
  input logic              i_reset,
  wbuconsole_link_if.slave bus
);

  // ---------------- receive path ----------------
  logic       rsp_push, con_push;
  logic       rsp_ok, con_ok;
  logic       rsp_full, con_full;
  logic       rsp_empty, con_empty;
  logic [1:0] overflow;
  logic       unused_full;

  assign rsp_push = bus.i_link_stb && (bus.i_link_data[7] == TAG_BUS);
  assign con_push = bus.i_link_stb && (bus.i_link_data[7] == TAG_CONSOLE);
  assign unused_full = &{1'b0, rsp_full, con_full};

  wbuconsole_fifo #(.WIDTH(7), .LGFIFO(LGFIFO)) u_rsp_fifo (
    .clk       (i_clk),
    .rst       (i_reset),
    .push      (rsp_push),
    .push_data (bus.i_link_data[6:0]),
    .pop       (bus.i_rsp_ready),
    .head      (bus.o_rsp_data),
    .full      (rsp_full),
    .empty     (rsp_empty),
    .push_ok   (rsp_ok)
  );

  wbuconsole_fifo #(.WIDTH(7), .LGFIFO(LGFIFO)) u_con_fifo (
    .clk       (i_clk),
    .rst       (i_reset),
    .push      (con_push),
    .push_data (bus.i_link_data[6:0]),
    .pop       (bus.i_conrx_ready),
    .head      (bus.o_conrx_data),
    .full      (con_full),
    .empty     (con_empty),
    .push_ok   (con_ok)
  );

  assign bus.o_rsp_stb   = !rsp_empty;
  assign bus.o_conrx_stb = !con_empty;
  assign bus.o_overflow  = overflow;

  // Sticky drop flags; a drop in the clearing cycle wins over the clear
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      overflow <= 2'b00;
    end else begin
      overflow[1] <= (overflow[1] && !bus.i_clr_overflow) || (rsp_push && !rsp_ok);
      overflow[0] <= (overflow[0] && !bus.i_clr_overflow) || (con_push && !con_ok);
    end
  end

  // ---------------- transmit path ----------------
  logic       hold_full;
  logic [7:0] hold_data;
  grant_t     last_grant;
  logic       cmd_busy, con_busy;
  logic       cmd_take, con_take;

  // The source granted last yields when the other one is also waiting
  assign cmd_busy = hold_full || (bus.i_con_stb && (last_grant == GRANT_CMD));
  assign con_busy = hold_full || (bus.i_cmd_stb && (last_grant == GRANT_CON));
  assign cmd_take = bus.i_cmd_stb && !cmd_busy;
  assign con_take = bus.i_con_stb && !con_busy;

  assign bus.o_cmd_busy  = cmd_busy;
  assign bus.o_con_busy  = con_busy;
  assign bus.o_link_stb  = hold_full;
  assign bus.o_link_data = hold_data;

  // Holding register: drains on link acceptance, loads only on a later empty cycle
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      hold_full  <= 1'b0;
      hold_data  <= 8'h00;
      last_grant <= GRANT_CON;
    end else if (hold_full) begin
      if (!bus.i_link_busy) hold_full <= 1'b0;
    end else if (cmd_take) begin
      hold_full  <= 1'b1;
      hold_data  <= tag_byte(TAG_BUS, bus.i_cmd_data);
      last_grant <= GRANT_CMD;
    end else if (con_take) begin
      hold_full  <= 1'b1;
      hold_data  <= tag_byte(TAG_CONSOLE, bus.i_con_data);
      last_grant <= GRANT_CON;
    end
  end

endmodule

// File: tb/tb_wbuconsole_link.sv
// tb/tb_wbuconsole_link.sv - directed self-checking bench for wbuconsole_link
module tb_wbuconsole_link;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  wbuconsole_link_if lnk();

  wbuconsole_link #(.LGFIFO(4)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (lnk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and land safely after the edge
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  logic [7:0] seen [4];
  logic [7:0] want [4];
  int         got;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    lnk.i_link_stb = 1'b0;  lnk.i_link_data = 8'h00;  lnk.i_link_busy = 1'b0;
    lnk.i_cmd_stb = 1'b0;   lnk.i_cmd_data = 7'h00;
    lnk.i_con_stb = 1'b0;   lnk.i_con_data = 7'h00;
    lnk.i_rsp_ready = 1'b0; lnk.i_conrx_ready = 1'b0;
    lnk.i_clr_overflow = 1'b0;
    repeat (2) step();

    // Reset state
    check("rst_link_stb",  32'(lnk.o_link_stb), 0);
    check("rst_link_data", 32'(lnk.o_link_data), 0);
    check("rst_rsp_stb",   32'(lnk.o_rsp_stb), 0);
    check("rst_conrx_stb", 32'(lnk.o_conrx_stb), 0);
    check("rst_overflow",  32'(lnk.o_overflow), 0);
    check("rst_cmd_busy",  32'(lnk.o_cmd_busy), 0);
    rst = 1'b0;

    // Reset in the middle of a blocked transmission
    lnk.i_link_busy = 1'b1;
    lnk.i_cmd_stb = 1'b1; lnk.i_cmd_data = 7'h15;
    lnk.i_link_stb = 1'b1; lnk.i_link_data = 8'h33;
    step();
    lnk.i_cmd_stb = 1'b0; lnk.i_link_stb = 1'b0;
    check("mid_link_stb",  32'(lnk.o_link_stb), 1);
    check("mid_link_data", 32'(lnk.o_link_data), 32'h95);
    check("mid_conrx_stb", 32'(lnk.o_conrx_stb), 1);
    #1 rst = 1'b1;
    #1;
    check("arst_link_stb",  32'(lnk.o_link_stb), 0);
    check("arst_conrx_stb", 32'(lnk.o_conrx_stb), 0);
    check("arst_rsp_stb",   32'(lnk.o_rsp_stb), 0);
    check("arst_overflow",  32'(lnk.o_overflow), 0);
    step();
    rst = 1'b0;
    lnk.i_link_busy = 1'b0;

    // Receive demux with per-stream ordering
    lnk.i_link_stb = 1'b1; lnk.i_link_data = 8'h81;
    step();
    check("rx_fwft_rsp_stb",  32'(lnk.o_rsp_stb), 1);
    check("rx_fwft_rsp_data", 32'(lnk.o_rsp_data), 32'h01);
    check("rx_fwft_con_stb",  32'(lnk.o_conrx_stb), 0);
    lnk.i_link_data = 8'h41;
    step();
    lnk.i_link_data = 8'hFF;
    step();
    lnk.i_link_stb = 1'b0;
    check("rx_rsp_head0",  32'(lnk.o_rsp_data), 32'h01);
    check("rx_con_head0",  32'(lnk.o_conrx_data), 32'h41);
    lnk.i_rsp_ready = 1'b1;
    step();
    check("rx_rsp_head1",  32'(lnk.o_rsp_data), 32'h7F);
    check("rx_rsp_stb1",   32'(lnk.o_rsp_stb), 1);
    lnk.i_conrx_ready = 1'b1;
    step();
    lnk.i_rsp_ready = 1'b0; lnk.i_conrx_ready = 1'b0;
    check("rx_rsp_drained", 32'(lnk.o_rsp_stb), 0);
    check("rx_con_drained", 32'(lnk.o_conrx_stb), 0);

    // Console overflow: 17 bytes into a 16-deep FIFO
    for (int i = 0; i < 17; i++) begin
      lnk.i_link_stb = 1'b1; lnk.i_link_data = 8'(i);
      step();
      if (i == 15) check("ovf_before_drop", 32'(lnk.o_overflow), 0);
    end
    lnk.i_link_stb = 1'b0;
    check("ovf_set",       32'(lnk.o_overflow), 32'h1);
    check("ovf_head",      32'(lnk.o_conrx_data), 32'h00);
    step();
    check("ovf_sticky",    32'(lnk.o_overflow), 32'h1);
    lnk.i_clr_overflow = 1'b1;
    step();
    lnk.i_clr_overflow = 1'b0;
    check("ovf_cleared",   32'(lnk.o_overflow), 0);

    // Push into the full FIFO while popping
    lnk.i_conrx_ready = 1'b1;
    lnk.i_link_stb = 1'b1; lnk.i_link_data = 8'h22;
    step();
    lnk.i_link_stb = 1'b0; lnk.i_conrx_ready = 1'b0;
    check("fullpop_no_ovf", 32'(lnk.o_overflow), 0);
    lnk.i_conrx_ready = 1'b1;
    for (int k = 1; k < 16; k++) begin
      check($sformatf("drain_%0d", k), 32'(lnk.o_conrx_data), 32'(k));
      step();
    end
    check("drain_last", 32'(lnk.o_conrx_data), 32'h22);
    step();
    check("drain_empty", 32'(lnk.o_conrx_stb), 0);
    lnk.i_conrx_ready = 1'b0;

    // Contention from reset: cmd wins first, then alternation
    rst = 1'b1;
    lnk.i_cmd_stb = 1'b1; lnk.i_cmd_data = 7'h05;
    lnk.i_con_stb = 1'b1; lnk.i_con_data = 7'h06;
    lnk.i_link_busy = 1'b0;
    step();
    rst = 1'b0;
    want[0] = 8'h85; want[1] = 8'h06; want[2] = 8'h85; want[3] = 8'h06;
    got = 0;
    for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
      step();
      if (lnk.o_link_stb) begin
        seen[got] = lnk.o_link_data;
        got++;
      end
    end
    lnk.i_cmd_stb = 1'b0; lnk.i_con_stb = 1'b0;
    check("arb_count", 32'(got), 4);
    for (int k = 0; k < 4; k++)
      if (k < got) check($sformatf("arb_byte_%0d", k), 32'(seen[k]), 32'(want[k]));

    // Backpressure with a held byte
    for (int cyc = 0; cyc < 10 && lnk.o_link_stb; cyc++) step();
    check("bp_idle", 32'(lnk.o_link_stb), 0);
    lnk.i_link_busy = 1'b1;
    lnk.i_cmd_stb = 1'b1; lnk.i_cmd_data = 7'h2A;
    step();
    lnk.i_cmd_stb = 1'b0;
    lnk.i_con_stb = 1'b1; lnk.i_con_data = 7'h11;
    #1;
    for (int k = 0; k < 10; k++) begin
      check("bp_link_stb",  32'(lnk.o_link_stb), 1);
      check("bp_link_data", 32'(lnk.o_link_data), 32'hAA);
      check("bp_cmd_busy",  32'(lnk.o_cmd_busy), 1);
      check("bp_con_busy",  32'(lnk.o_con_busy), 1);
      step();
      #1;
    end
    lnk.i_link_busy = 1'b0;
    step();
    #1;
    check("bp_emptied",   32'(lnk.o_link_stb), 0);
    check("bp_con_free",  32'(lnk.o_con_busy), 0);
    step();
    lnk.i_con_stb = 1'b0;
    check("bp_next_stb",  32'(lnk.o_link_stb), 1);
    check("bp_next_data", 32'(lnk.o_link_data), 32'h11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wbuconsole_link.md
Name: wbuconsole_link

Overview:
Link-side counterpart of the console/bus multiplexer. It sits at the far end of a single 8-bit byte link and separates and combines the two streams carried on it.
- Receive: demultiplexes incoming link bytes by bit 7. Bit 7 = 1 is a bus response; bit 7 = 0 is console data. Each stream goes into its own FIFO.
- Transmit: merges an outgoing bus-command stream and a console stream onto the link. Each byte is tagged with its bit-7 marker; the two sources are arbitrated round-robin.

Parameters:
- LGFIFO, 4, log2 depth of each receive FIFO (16 entries).

Ports:
- i_clk  in  1  system clock; single clock domain
- i_reset  in  1  asynchronous, active-high reset
- i_link_stb  in  1  byte received from the link this cycle
- i_link_data  in  8  received link byte; bit 7 is the stream tag
- o_link_stb  out  1  byte pending for the link transmitter
- o_link_data  out  8  tagged byte for the link
- i_link_busy  in  1  link transmitter cannot accept a byte
- i_cmd_stb  in  1  outgoing bus-command byte valid
- i_cmd_data  in  7  bus-command payload
- o_cmd_busy  out  1  command byte not accepted this cycle
- i_con_stb  in  1  outgoing console byte valid
- i_con_data  in  7  console payload
- o_con_busy  out  1  console byte not accepted this cycle
- o_rsp_stb  out  1  bus-response FIFO non-empty
- o_rsp_data  out  7  bus-response FIFO head
- i_rsp_ready  in  1  pop response FIFO when o_rsp_stb
- o_conrx_stb  out  1  console-receive FIFO non-empty
- o_conrx_data  out  7  console-receive FIFO head
- i_conrx_ready  in  1  pop console FIFO when o_conrx_stb
- i_clr_overflow  in  1  clear sticky overflow flags
- o_overflow  out  2  sticky drop flags {rsp, console}

Behaviour:
- Reset is asynchronous and active-high. On reset:
  - all outputs are 0;
  - both FIFOs are empty;
  - the holding register is empty;
  - the last-grant register is set to console, so the command source wins the first contention.
- Reset asserted mid-transmission discards the held byte. o_link_stb drops immediately.

Receive path:
- When i_link_stb is high, bit 7 selects the destination: 1 pushes data[6:0] into the rsp FIFO, 0 pushes it into the console FIFO.
- A push is accepted if the FIFO is not full, or if a pop of that FIFO occurs in the same cycle.
- If the push is not accepted, the byte is dropped and the matching o_overflow bit is set next cycle.
- Overflow bits are sticky. They clear on i_clr_overflow; if a new drop occurs in the same cycle as the clear, the bit stays set.
- FIFO outputs are first-word-fall-through. A pushed byte appears on o_*_stb/data one cycle after i_link_stb.
- A pop happens when stb && ready. Popping on empty is ignored.
- Pointers are LGFIFO+1 bits wide and wrap modulo 2^(LGFIFO+1). Full means the MSBs differ and the lower bits are equal.

Transmit path:
- There is a single holding register (full flag plus 8-bit data). o_link_stb = full flag; o_link_data = held data.
- When the register is empty, at most one source is accepted:
  - only cmd valid: grant cmd;
  - only con valid: grant con;
  - both valid: grant the source that is not the last grant.
- The granted source loads {1'b1, cmd} or {1'b0, con}. The last-grant register updates.
- Busy outputs are combinational:
  - o_cmd_busy = full || (i_con_stb && last_grant == cmd);
  - o_con_busy = full || (i_cmd_stb && last_grant == con).
- Acceptance is stb && !busy. The accepted byte is on o_link_stb the next cycle.
- The register empties on the cycle after one where o_link_stb && !i_link_busy. No new byte loads in that cycle (one-cycle bubble; maximum throughput is one byte per 2 cycles).
- A source must hold its stb and data while busy.

Decomposition:
- Shared package:
  - TAG_BUS = 1'b1;
  - TAG_CONSOLE = 1'b0;
  - grant encoding GRANT_CMD = 1'b1, GRANT_CON = 1'b0.
- Sub-module wbuconsole_fifo: synchronous FWFT FIFO with parameters width and LGFIFO. It is instantiated twice and provides full, empty and push-accepted signals. The arbiter and demux stay in the top level.

Test Plan:
- Reset mid-transmission: load cmd 0x15, assert i_reset while i_link_busy=1 → o_link_stb=0 immediately; both FIFOs empty; o_overflow=0.
- Receive sequence 0x81, 0x41, 0xFF → rsp FIFO yields 0x01 then 0x7F; console FIFO yields 0x41; order preserved per stream.
- Console overflow: 17 console bytes with no pops (LGFIFO=4) → first 16 retained; 17th dropped; o_overflow=2'b01. i_clr_overflow → 2'b00.
- Full-with-pop: console FIFO full, pop and push 0x22 in the same cycle → push accepted; no overflow; 0x22 appears after the other 15 entries.
- Contention: cmd 0x05 and con 0x06 valid together, continuously from reset → link emits 0x85, 0x06, 0x85, 0x06 (alternating, cmd first).
- Backpressure: i_link_busy=1 for 10 cycles with a byte held → o_link_stb stays 1 with stable data; both busy outputs stay 1. Release → holding register empties the next cycle, next byte loads the cycle after.
